subservient_boot_loader: RTL and testbench

Firmware boot loader that sits directly upstream of the subservient core's debug Wishbone port. It accepts a length-prefixed byte stream over a valid/ready interface, packs the bytes little-endian into 32-bit words, and writes them into core memory as Wishbone classic single writes starting at address 0. It holds the core in debug mode until the image is fully written, then releases it to run.

---
 rtl/subservient_boot_loader_if.sv | 24 ++
 rtl/subservient_boot_loader.sv | 128 ++++++++++++
 tb/tb_subservient_boot_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/subservient_boot_loader_if.sv
// Byte-stream and Wishbone write-port bundle for the subservient boot loader.
// The loader uses the master modport; the stream source and core debug port use slave.
interface subservient_boot_loader_if;
    logic        i_byte_valid;
    logic [7:0]  i_byte;
    logic        o_byte_ready;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_stb;
    logic        o_wb_cyc;
    logic        i_wb_ack;

    modport master (
        input  i_byte_valid, i_byte, i_wb_ack,
        output o_byte_ready, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_stb, o_wb_cyc
    );

    modport slave (
        output i_byte_valid, i_byte, i_wb_ack,
        input  o_byte_ready, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_stb, o_wb_cyc
    );
endinterface

// File: rtl/subservient_boot_loader.sv
// Boot loader: takes a length-prefixed byte stream, packs it into little-endian words
// and writes them to core memory from address 0, holding the core in debug until done.
module subservient_boot_loader #(
    parameter int MEMSIZE = 512,
    parameter int AW      = $clog2(MEMSIZE)
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic                       i_start,
    subservient_boot_loader_if.master  bus,
    output logic                       o_debug_mode,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_FILL, S_WRITE, S_DONE, S_ERR
    } state_e;

    // One extra bit so the remaining counter can hold MEMSIZE itself.
    localparam int          CW      = AW + 1;
    localparam logic [15:0] MAX_LEN = 16'(MEMSIZE);

    state_e        state_q, state_d;
    logic [7:0]    len_lo_q, len_lo_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   buf_q, buf_d;
    logic [3:0]    sel_q, sel_d;
    logic [15:0]   len;
    logic          byte_hs;

    assign byte_hs = bus.i_byte_valid && bus.o_byte_ready;
    assign len     = {bus.i_byte, len_lo_q};

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        len_lo_d = len_lo_q;
        rem_d    = rem_q;
        adr_d    = adr_q;
        lane_d   = lane_q;
        buf_d    = buf_q;
        sel_d    = sel_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) state_d = S_LEN0;
            end
            S_LEN0: begin
                if (byte_hs) begin
                    len_lo_d = bus.i_byte;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (byte_hs) begin
                    if (len == 16'd0 || len > MAX_LEN) begin
                        state_d = S_ERR;
                    end else begin
                        rem_d   = len[CW-1:0];
                        adr_d   = '0;
                        lane_d  = '0;
                        sel_d   = '0;
                        buf_d   = '0;
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (byte_hs) begin
                    buf_d[8*lane_q +: 8] = bus.i_byte;
                    sel_d[lane_q]        = 1'b1;
                    lane_d               = lane_q + 2'd1;
                    rem_d                = rem_q - CW'(1);
                    if (lane_q == 2'd3 || rem_q == CW'(1)) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Buffer is cleared after each write so a short final word carries zeros.
                if (bus.i_wb_ack) begin
                    adr_d   = adr_q + AW'(4);
                    lane_d  = '0;
                    sel_d   = '0;
                    buf_d   = '0;
                    state_d = (rem_q == '0) ? S_DONE : S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!wb_rst_ni) begin
            state_q  <= S_IDLE;
            len_lo_q <= '0;
            rem_q    <= '0;
            adr_q    <= '0;
            lane_q   <= '0;
            buf_q    <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            rem_q    <= rem_d;
            adr_q    <= adr_d;
            lane_q   <= lane_d;
            buf_q    <= buf_d;
            sel_q    <= sel_d;
        end
    end

    // Outputs decode the registered state, so reset drops the strobe asynchronously.
    assign bus.o_byte_ready = state_q inside {S_LEN0, S_LEN1, S_FILL};
    assign bus.o_wb_stb     = (state_q == S_WRITE);
    assign bus.o_wb_cyc     = (state_q == S_WRITE);
    assign bus.o_wb_we      = (state_q == S_WRITE);
    assign bus.o_wb_adr     = {{(32-AW){1'b0}}, adr_q};
    assign bus.o_wb_dat     = buf_q;
    assign bus.o_wb_sel     = sel_q;
    assign o_debug_mode     = (state_q != S_DONE);
    assign o_busy           = !(state_q inside {S_IDLE, S_DONE, S_ERR});
    assign o_done           = (state_q == S_DONE);
    assign o_err            = (state_q == S_ERR);

endmodule

// File: tb/tb_subservient_boot_loader.sv
// Self-checking bench for subservient_boot_loader: directed and randomized loads
// compared against a word-level model of the expected Wishbone writes.
module tb_subservient_boot_loader;

    localparam int MEMSIZE = 512;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wr_t;

    logic wb_clk_i  = 1'b0;
    logic wb_rst_ni = 1'b0;
    logic i_start   = 1'b0;
    logic o_debug_mode, o_busy, o_done, o_err;

    subservient_boot_loader_if bus();

    subservient_boot_loader #(.MEMSIZE(MEMSIZE)) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_ni    (wb_rst_ni),
        .i_start      (i_start),
        .bus          (bus),
        .o_debug_mode (o_debug_mode),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [7:0] stream_q[$];
    wr_t        exp_q[$];
    wr_t        obs_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " debug_mode"}, 64'(o_debug_mode), 64'(1));
        check({tag, " quiet outputs"},
              64'({bus.o_byte_ready, bus.o_wb_stb, bus.o_wb_cyc, bus.o_wb_we,
                   bus.o_wb_sel, o_busy, o_done, o_err}), 64'(0));
        check({tag, " adr"}, 64'(bus.o_wb_adr), 64'(0));
        check({tag, " dat"}, 64'(bus.o_wb_dat), 64'(0));
    endtask

    // Word-level model: header gives length; each group of four data bytes is one write.
    function automatic bit build_model();
        int len = int'({stream_q[1], stream_q[0]});
        bit ok  = (len != 0) && (len <= MEMSIZE);
        exp_q.delete();
        if (ok) begin
            for (int w = 0; w * 4 < len; w++) begin
                wr_t t;
                t.adr = 32'(w * 4);
                t.dat = '0;
                t.sel = '0;
                for (int b = 0; b < 4; b++) begin
                    if (w * 4 + b < len) begin
                        t.dat[8*b +: 8] = stream_q[2 + w*4 + b];
                        t.sel[b]        = 1'b1;
                    end
                end
                exp_q.push_back(t);
            end
        end
        return ok;
    endfunction

    task automatic make_stream(input logic [15:0] len_field, input int n_data);
        stream_q.delete();
        stream_q.push_back(len_field[7:0]);
        stream_q.push_back(len_field[15:8]);
        for (int i = 0; i < n_data; i++) stream_q.push_back(8'($urandom));
    endtask

    // Pulses i_start, streams stream_q, answers writes after ack_dly cycles, checks timing.
    task automatic run_load(input string name, input int ack_dly, input bit rand_valid);
        bit  ok;
        int  len;
        int  idx = 0, wait_cnt = 0, cyc = 0, ack_cyc = -10;
        bit  in_wr = 0, word_done = 0, finished = 0;
        wr_t held = '0;
        ok  = build_model();
        len = int'({stream_q[1], stream_q[0]});
        obs_q.delete();
        i_start = 1'b1;
        @(negedge wb_clk_i);
        i_start = 1'b0;
        check({name, " start->ready"}, 64'(bus.o_byte_ready), 64'(1));
        while (!finished && cyc < 4000) begin
            if (word_done) check({name, " word->stb"}, 64'(bus.o_wb_stb), 64'(1));
            word_done = 0;
            if (cyc == ack_cyc + 1) begin
                check({name, " stb gap"}, 64'(bus.o_wb_stb), 64'(0));
                if (idx < stream_q.size())
                    check({name, " ack->ready"}, 64'(bus.o_byte_ready), 64'(1));
                else
                    check({name, " ack->done/debug"}, 64'({o_done, o_debug_mode}), 64'(2'b10));
            end
            if (o_done || o_err) begin
                finished = 1;
            end else begin
                bus.i_wb_ack = 1'b0;
                if (bus.o_wb_stb) begin
                    if (!in_wr) begin
                        held     = '{adr: bus.o_wb_adr, dat: bus.o_wb_dat, sel: bus.o_wb_sel};
                        in_wr    = 1;
                        wait_cnt = 0;
                    end else begin
                        check({name, " held adr/dat/sel"},
                              64'({bus.o_wb_adr[27:0], bus.o_wb_dat, bus.o_wb_sel}),
                              64'({held.adr[27:0], held.dat, held.sel}));
                    end
                    check({name, " cyc/we/ready in write"},
                          64'({bus.o_wb_cyc, bus.o_wb_we, bus.o_byte_ready}), 64'(3'b110));
                    if (wait_cnt == ack_dly) begin
                        bus.i_wb_ack = 1'b1;
                        obs_q.push_back(held);
                        in_wr   = 0;
                        ack_cyc = cyc;
                    end
                    wait_cnt++;
                end else if (rand_valid) begin
                    bus.i_wb_ack = 1'($urandom_range(0, 1));
                end
                if (idx < stream_q.size() && (!rand_valid || $urandom_range(0, 1) == 1)) begin
                    bus.i_byte_valid = 1'b1;
                    bus.i_byte       = stream_q[idx];
                end else begin
                    bus.i_byte_valid = 1'b0;
                    bus.i_byte       = 8'($urandom);
                end
                if (bus.i_byte_valid && bus.o_byte_ready) begin
                    if (ok && idx >= 2 && (((idx - 2) % 4 == 3) || (idx - 2 == len - 1)))
                        word_done = 1;
                    idx++;
                end
                @(negedge wb_clk_i);
                cyc++;
            end
        end
        bus.i_byte_valid = 1'b0;
        bus.i_wb_ack     = 1'b0;
        check({name, " finished in budget"}, 64'(finished), 64'(1));
        check({name, " done/err/debug/busy"}, 64'({o_done, o_err, o_debug_mode, o_busy}),
              64'({ok, !ok, !ok, 1'b0}));
        check({name, " bytes consumed"}, 64'(idx), 64'(stream_q.size()));
        check({name, " write count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s write %0d adr", name, i), 64'(obs_q[i].adr), 64'(exp_q[i].adr));
            check($sformatf("%s write %0d dat", name, i), 64'(obs_q[i].dat), 64'(exp_q[i].dat));
            check($sformatf("%s write %0d sel", name, i), 64'(obs_q[i].sel), 64'(exp_q[i].sel));
        end
    endtask

    initial begin
        bus.i_byte_valid = 1'b0;
        bus.i_byte       = 8'h00;
        bus.i_wb_ack     = 1'b0;

        // Reset and idle
        #3;
        check_idle("in reset");
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        check_idle("idle after reset");

        // Full 8-byte image
        stream_q = {8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_load("load8", 1, 1'b0);

        // Partial last word
        stream_q = {8'h05, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_load("partial", 1, 1'b0);

        // Backpressure: slow ack, random valid, spurious acks while idle on the bus
        make_stream(16'd23, 23);
        run_load("backpressure", 3, 1'b1);

        // Rejected headers, then recovery
        make_stream(16'h0000, 0);
        run_load("len0", 1, 1'b0);
        make_stream(16'h0201, 0);
        run_load("len513", 1, 1'b0);
        make_stream(16'd6, 6);
        run_load("after err", 0, 1'b0);

        // Largest accepted image
        make_stream(16'(MEMSIZE), MEMSIZE);
        run_load("len512", 0, 1'b0);

        // Mid-load reset while the strobe is up
        stream_q = {8'h04, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        i_start = 1'b1;
        @(negedge wb_clk_i);
        i_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.i_byte_valid = 1'b1;
            bus.i_byte       = stream_q[i];
            @(negedge wb_clk_i);
        end
        bus.i_byte_valid = 1'b0;
        check("mid-reset stb before", 64'(bus.o_wb_stb), 64'(1));
        #2 wb_rst_ni = 1'b0;
        #1 check_idle("mid-reset");
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        make_stream(16'd10, 10);
        run_load("after reset", 2, 1'b1);

        // Randomized loads
        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(1, 60));
            make_stream(16'(n), n);
            run_load($sformatf("random%0d", r), int'($urandom_range(0, 4)), 1'b1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
